// File: rtl/gravity_sensor_spi_master_if.sv
// Bundle of signals between the accelerometer link master and the rest of the
// system. The master modport is the link initiator; slave is whoever hosts it
// (sensor pins plus game-control consumer).
//   enable       : run sweeps continuously (sampled only between sweeps)
//   data         : serial data from sensor (MISO)
//   clkcs        : chip select, active-low
//   sclk         : serial clock, idles low
//   mosi         : serial command/address stream
//   x_value      : last complete X sample, two's complement
//   y_value      : last complete Y sample, two's complement
//   sample_valid : one-cycle strobe when x_value/y_value update together
//   busy         : a sweep is in progress
interface gravity_sensor_spi_master_if;
  logic        enable;
  logic        data;
  logic        clkcs;
  logic        sclk;
  logic        mosi;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic        sample_valid;
  logic        busy;

  modport master (
    input  enable, data,
    output clkcs, sclk, mosi, x_value, y_value, sample_valid, busy
  );

  modport slave (
    output enable, data,
    input  clkcs, sclk, mosi, x_value, y_value, sample_valid, busy
  );
endinterface

// File: rtl/gravity_sensor_spi_master.sv
// Accelerometer serial link master. Sweeps the X_H, X_L, Y_H, Y_L registers
// with one 24-bit read frame each ({READ_CMD, addr, 8'h00}), assembles the
// 12-bit X/Y samples and publishes them as a pair with a one-cycle strobe.
// Ports:
//   clk1 : system clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : link/sample signals (see gravity_sensor_spi_master_if), master side
module gravity_sensor_spi_master #(
  parameter int unsigned CLK_DIV  = 4,     // clk1 cycles per sclk half-period
  parameter int unsigned CS_GAP   = 8,     // clk1 cycles clkcs high between frames
  parameter logic [7:0]  READ_CMD = 8'h0B,
  parameter logic [7:0]  ADDR_XH  = 8'h0F,
  parameter logic [7:0]  ADDR_XL  = 8'h0E,
  parameter logic [7:0]  ADDR_YH  = 8'h11,
  parameter logic [7:0]  ADDR_YL  = 8'h10
) (
  input  logic                          clk1,
  input  logic                          rst,
  gravity_sensor_spi_master_if.master   bus
);

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(CS_GAP - 1);
  // The DONE cycle is the final clkcs-high cycle after the Y_L frame.
  localparam logic [CNT_W-1:0] GAP_LAST_YL = CNT_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [4:0]       LAST_BIT    = 5'(FRAME_BITS - 1);
  localparam logic [1:0]       FRAME_YL    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic             phase_hi_q, phase_hi_d;
  logic [1:0]       frame_q, frame_d;
  logic [6:0]       rx_q, rx_d;
  logic [11:0]      shadow_x_q, shadow_x_d;
  logic [11:0]      shadow_y_q, shadow_y_d;

  logic             clkcs_q, clkcs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [11:0]      x_value_q, x_value_d;
  logic [11:0]      y_value_q, y_value_d;
  logic             sample_valid_q, sample_valid_d;
  logic             busy_q, busy_d;

  logic             rise;
  logic [7:0]       rx_byte;
  logic [23:0]      tx_word;
  logic [4:0]       tx_idx;

  // Frame word for a given sweep position.
  function automatic logic [23:0] frame_word(input logic [1:0] f);
    logic [7:0] a;
    case (f)
      2'd0:    a = ADDR_XH;
      2'd1:    a = ADDR_XL;
      2'd2:    a = ADDR_YH;
      default: a = ADDR_YL;
    endcase
    return {READ_CMD, a, 8'h00};
  endfunction

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_d          = bit_q;
    phase_hi_d     = phase_hi_q;
    frame_d        = frame_q;
    rx_d           = rx_q;
    shadow_x_d     = shadow_x_q;
    shadow_y_d     = shadow_y_q;
    x_value_d      = x_value_q;
    y_value_d      = y_value_q;
    rise           = 1'b0;
    rx_byte        = {rx_q, bus.data};
    tx_word        = 24'h0;
    tx_idx         = 5'd0;
    mosi_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_CS_SETUP;
          cnt_d   = '0;
          frame_d = 2'd0;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          phase_hi_d = 1'b1;
          bit_d      = 5'd0;
          rise       = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (phase_hi_q) begin
            phase_hi_d = 1'b0;
            // Low phase after the last bit is the chip-select hold time.
            if (bit_q == LAST_BIT) state_d = ST_CS_HOLD;
          end else begin
            phase_hi_d = 1'b1;
            bit_d      = bit_q + 5'd1;
            rise       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if ((frame_q == FRAME_YL) && (GAP_LAST == '0)) state_d = ST_DONE;
          else                                           state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (((frame_q == FRAME_YL) && (cnt_q == GAP_LAST_YL)) ||
            ((frame_q != FRAME_YL) && (cnt_q == GAP_LAST))) begin
          cnt_d = '0;
          if (frame_q == FRAME_YL) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CS_SETUP;
            frame_d = frame_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        frame_d = 2'd0;
        state_d = bus.enable ? ST_CS_SETUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // MISO sampled on the edge that raises sclk; bits 17..24 form the byte.
    if (rise) begin
      rx_d = rx_byte[6:0];
      if (bit_d == LAST_BIT) begin
        case (frame_q)
          2'd0:    shadow_x_d[11:8] = rx_byte[3:0];
          2'd1:    shadow_x_d[7:0]  = rx_byte;
          2'd2:    shadow_y_d[11:8] = rx_byte[3:0];
          default: shadow_y_d[7:0]  = rx_byte;
        endcase
      end
    end

    // Outputs follow the state being entered so they register with it.
    tx_word = frame_word(frame_d);
    if (state_d == ST_CS_SETUP) begin
      mosi_d = tx_word[LAST_BIT];
    end else if (state_d == ST_SHIFT) begin
      // In a low phase the next bit is already presented (changes on sclk fall).
      tx_idx = phase_hi_d ? bit_d : bit_d + 5'd1;
      mosi_d = tx_word[LAST_BIT - tx_idx];
    end

    clkcs_d        = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) ||
                       (state_d == ST_CS_HOLD));
    sclk_d         = (state_d == ST_SHIFT) && phase_hi_d;
    busy_d         = (state_d != ST_IDLE);
    sample_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      x_value_d = shadow_x_q;
      y_value_d = shadow_y_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_q          <= 5'd0;
      phase_hi_q     <= 1'b0;
      frame_q        <= 2'd0;
      rx_q           <= 7'd0;
      shadow_x_q     <= 12'd0;
      shadow_y_q     <= 12'd0;
      clkcs_q        <= 1'b1;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      x_value_q      <= 12'd0;
      y_value_q      <= 12'd0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      phase_hi_q     <= phase_hi_d;
      frame_q        <= frame_d;
      rx_q           <= rx_d;
      shadow_x_q     <= shadow_x_d;
      shadow_y_q     <= shadow_y_d;
      clkcs_q        <= clkcs_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      x_value_q      <= x_value_d;
      y_value_q      <= y_value_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.clkcs        = clkcs_q;
  assign bus.sclk         = sclk_q;
  assign bus.mosi         = mosi_q;
  assign bus.x_value      = x_value_q;
  assign bus.y_value      = y_value_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.busy         = busy_q;

endmodule
